rx_timer: RTL and testbench

Bit-timing generator for the packet receive path, the receive-side counterpart of the transmit bit timer. While the receive controller holds `enable_timer`, it divides `clk` into 8-cycle bit periods and emits a one-cycle `shift_strobe` at each bit's mid-point for the receive shift register. It pulses `byte_received` on every 8th strobe. Optionally, it re-aligns its phase to line transitions reported by the edge detector.

---
 rtl/usb_timing_pkg.sv | 9 +
 rtl/rx_phase_counter.sv | 30 +++
 rtl/rx_timer.sv | 76 +++++++
 tb/tb_rx_timer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/usb_timing_pkg.sv
// Bit-timing constants shared by the transmit and receive bit timers.
package usb_timing_pkg;

  localparam int unsigned BIT_PERIOD   = 8;
  localparam int unsigned SAMPLE_POINT = 4;
  localparam int unsigned DATA_LEN     = 8;
  localparam int unsigned CNT_BITS     = 4;

endpackage

// File: rtl/rx_phase_counter.sv
// Bit-period phase counter: wraps at BIT_PERIOD-1.
// Synchronous clear has priority over load-to-1.
module rx_phase_counter
  import usb_timing_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                load_one,
  output logic [CNT_BITS-1:0] p
);

  logic [CNT_BITS-1:0] p_q;
  logic [CNT_BITS-1:0] p_d;

  always_comb begin
    p_d = p_q + CNT_BITS'(1);
    if (p_q == CNT_BITS'(BIT_PERIOD - 1)) p_d = '0;
    if (load_one)                         p_d = CNT_BITS'(1);
    if (clear)                            p_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) p_q <= '0;
    else     p_q <= p_d;
  end

  assign p = p_q;

endmodule

// File: rtl/rx_timer.sv
// Receive bit timer: mid-bit shift strobe, byte-complete pulse and bit count.
// Optional phase resync to line edges when RX_TIMER_RESYNC_EN is defined.
module rx_timer
  import usb_timing_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_timer,
  input  logic                d_edge,
  output logic                shift_strobe,
  output logic                byte_received,
  output logic [CNT_BITS-1:0] bit_count,
  output logic                sync_error
);

  logic [CNT_BITS-1:0] p;
  logic                load_one;
  logic [CNT_BITS-1:0] bit_count_q;
  logic [CNT_BITS-1:0] bit_count_d;

  rx_phase_counter u_phase (
    .clk      (clk),
    .rst      (rst),
    .clear    (!enable_timer),
    .load_one (load_one),
    .p        (p)
  );

  always_comb begin
    shift_strobe  = enable_timer && (p == CNT_BITS'(SAMPLE_POINT));
    byte_received = shift_strobe && (bit_count_q == CNT_BITS'(DATA_LEN - 1));
  end

  always_comb begin
    bit_count_d = bit_count_q;
    if (!enable_timer)      bit_count_d = '0;
    else if (byte_received) bit_count_d = '0;
    else if (shift_strobe)  bit_count_d = bit_count_q + CNT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) bit_count_q <= '0;
    else     bit_count_q <= bit_count_d;
  end

  assign bit_count = bit_count_q;

`ifdef RX_TIMER_RESYNC_EN
  logic in_window;
  logic sync_error_q;
  logic sync_error_d;

  // Window is p in {BIT_PERIOD-1, 0, 1}; loading 1 at p=0 matches normal counting.
  always_comb begin
    in_window    = (p == CNT_BITS'(BIT_PERIOD - 1)) || (p == '0) || (p == CNT_BITS'(1));
    load_one     = enable_timer && d_edge && in_window;
    sync_error_d = sync_error_q;
    if (!enable_timer)               sync_error_d = 1'b0;
    else if (d_edge && !in_window)   sync_error_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sync_error_q <= 1'b0;
    else     sync_error_q <= sync_error_d;
  end

  assign sync_error = sync_error_q;
`else
  logic unused_d_edge;

  assign unused_d_edge = d_edge;
  assign load_one      = 1'b0;
  assign sync_error    = 1'b0;
`endif

endmodule

// File: tb/tb_rx_timer.sv
// Directed bench for rx_timer; resync scenarios apply when RX_TIMER_RESYNC_EN is defined.
module tb_rx_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable_timer = 1'b0;
  logic       d_edge = 1'b0;
  logic       shift_strobe;
  logic       byte_received;
  logic [3:0] bit_count;
  logic       sync_error;

  int total = 0;
  int bad   = 0;

  rx_timer dut (
    .clk           (clk),
    .rst           (rst),
    .enable_timer  (enable_timer),
    .d_edge        (d_edge),
    .shift_strobe  (shift_strobe),
    .byte_received (byte_received),
    .bit_count     (bit_count),
    .sync_error    (sync_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic drive(input logic en, input logic de, input logic r);
    @(posedge clk);
    #1;
    enable_timer = en;
    d_edge       = de;
    rst          = r;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0);
    check("idle.st", shift_strobe, 0);
    check("idle.br", byte_received, 0);
    drive(1'b0, 1'b0, 1'b0);
    check("idle.bc", bit_count, 0);
    check("idle.se", sync_error, 0);
  endtask

  // t=0 is the first enabled cycle; expected strobe times are set per scenario
  // as en && (t-base) mod 8 == 4, with bit count tracked from those strobes.
  task automatic run_scn(input int scn, input int n, input string name);
    int   nst;
    logic en, de, r, st, se;
    int   base;
    nst = 0;
    for (int t = 0; t < n; t++) begin
      en = 1'b1; de = 1'b0; r = 1'b0; se = 1'b0; base = 0;
      case (scn)
        1: begin
`ifdef RX_TIMER_RESYNC_EN
          de   = (t == 15);
          base = (t >= 16) ? 15 : 0;
`else
          de   = (t == 10) || (t == 15);
`endif
        end
        2: begin
          de   = (t == 10);
          en   = (t != 22);
          base = (t >= 23) ? 23 : 0;
`ifdef RX_TIMER_RESYNC_EN
          se   = (t >= 11) && (t <= 22);
`endif
        end
        3: begin
          de = (t == 4) || (t == 8);
`ifdef RX_TIMER_RESYNC_EN
          se = (t >= 5);
`endif
        end
        4: begin
          en   = !((t == 30) || (t == 35));
          de   = (t == 30) || (t == 35);
          base = (t < 31) ? 0 : ((t < 36) ? 31 : 36);
        end
        5: begin
          r    = (t == 40);
          base = (t <= 40) ? 0 : 41;
        end
        default: ;
      endcase
      st = en && (((t - base) % 8) == 4);
      drive(en, de, r);
      check($sformatf("%s.st@%0d", name, t), shift_strobe, st);
      check($sformatf("%s.br@%0d", name, t), byte_received, st && (nst == 7));
      check($sformatf("%s.bc@%0d", name, t), bit_count, nst);
      check($sformatf("%s.se@%0d", name, t), sync_error, se);
      if (r || !en)   nst = 0;
      else if (st)    nst = (nst + 1) % 8;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i[0], 1'b1);
      check("rst.st", shift_strobe, 0);
      check("rst.br", byte_received, 0);
      check("rst.bc", bit_count, 0);
      check("rst.se", sync_error, 0);
    end
    idle();

    run_scn(0, 70, "free");
    idle();
    run_scn(1, 40, "edge15");
    idle();
`ifdef RX_TIMER_RESYNC_EN
    run_scn(2, 25, "edge10");
    idle();
    run_scn(3, 14, "edge_on_strobe");
    idle();
`endif
    run_scn(4, 45, "disable");
    idle();
    run_scn(5, 110, "reset_mid");
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
